id_ctrl_stage: RTL and testbench

Registered decode/control stage for the RV32I core, sitting between the IF/ID boundary and the EX stage. It takes a fetched instruction and PC, fully decodes all base opcodes (R, I, L, S, B, JAL, JALR, LUI, AUIPC) into a control bundle plus immediate, and holds the result in a single-entry ID/EX register with a valid/ready handshake. It also detects load-use hazards (one-bubble stall), honours pipeline flush, and flags illegal encodings without dropping them.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/ctrl_decode.sv | 102 ++++++++++
 rtl/imm_gen.sv | 20 ++
 rtl/id_ctrl_stage.sv | 98 +++++++++
 tb/tb_id_ctrl_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants, ALU op codes, mux encodings and control bundle
package riscv_pkg;
  localparam int ALU_OP_W = 5;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'h00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'h08;
  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          a_sel;
    logic                alu_src;
    logic [1:0]          wb_sel;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic                jalr;
    logic                illegal;
  } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode/funct to control bundle, register fields and source usage; RV_MEXT_EN enables M ops
module ctrl_decode import riscv_pkg::*; #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0]           instr,
  output ctrl_t                 ctrl,
  output logic                  use_rs1,
  output logic                  use_rs2,
  output logic [2:0]            funct3,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd
);
  logic [6:0] f7;
  logic       m_ok, r_ok, sh_ok;
  assign f7     = instr[31:25];
  assign funct3 = instr[14:12];
  assign rs1    = instr[15 +: REG_ADDR_W];
  assign rs2    = instr[20 +: REG_ADDR_W];
  assign rd     = instr[7 +: REG_ADDR_W];
`ifdef RV_MEXT_EN
  assign m_ok = f7 == 7'h01;
`else
  assign m_ok = 1'b0;
`endif
  assign r_ok  = f7 == 7'h00 || (f7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) || m_ok;
  assign sh_ok = funct3 == 3'b001 ? f7 == 7'h00 : funct3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
  // per-opcode control, then rd==0 suppression and illegal squash
  always_comb begin
    ctrl    = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (instr[6:0])
      OP_R: begin
        ctrl.alu_op    = m_ok ? {2'b10, funct3} : {1'b0, f7[5], funct3};
        ctrl.reg_write = 1'b1;
        ctrl.illegal   = !r_ok;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_I: begin
        ctrl.alu_op    = funct3[1:0] == 2'b01 ? {1'b0, f7[5], funct3} : {2'b00, funct3};
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.illegal   = !sh_ok;
        use_rs1        = 1'b1;
      end
      OP_L: begin
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_MEM;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1        = 1'b1;
      end
      OP_S: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OP_B: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.a_sel     = A_PC;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        ctrl.jump      = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1        = 1'b1;
      end
      OP_LUI: begin
        ctrl.a_sel     = A_ZERO;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.a_sel     = A_PC;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (rd == '0) ctrl.reg_write = 1'b0;
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
    end
  end
endmodule

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate from an RV32I instruction word by format
module imm_gen import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  // select the immediate layout implied by the opcode
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_I, OP_L, OP_JALR: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_S:                imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_B:                imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_JAL:              imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC:    imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      default:             imm = '0;
    endcase
  end
endmodule

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: RV32I decode stage with ID/EX register, load-use stall and flush; RV_MEXT_EN adds M decode
module id_ctrl_stage import riscv_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_OP_W-1:0]   out_alu_op,
  output logic [1:0]            out_a_sel,
  output logic                  out_alu_src,
  output logic [1:0]            out_wb_sel,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_branch,
  output logic                  out_jump,
  output logic                  out_jalr,
  output logic [2:0]            out_funct3,
  output logic [XLEN-1:0]       out_imm,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_illegal
);
  ctrl_t                 dec, ctrl_d, ctrl_q;
  logic                  use_rs1, use_rs2, hazard, accept, valid_d, valid_q;
  logic [2:0]            f3, f3_d, f3_q;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd, rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [XLEN-1:0]       imm, imm_d, imm_q, pc_d, pc_q;
  ctrl_decode #(.REG_ADDR_W(REG_ADDR_W)) u_dec (
    .instr(in_instr), .ctrl(dec), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .funct3(f3), .rs1(rs1), .rs2(rs2), .rd(rd)
  );
  imm_gen #(.XLEN(XLEN)) u_imm (.instr(in_instr), .imm(imm));
  assign hazard   = valid_q && ctrl_q.mem_read && rd_q != '0 &&
                    ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q));
  assign in_ready = (!valid_q || out_ready) && !hazard && !flush && !rst;
  assign accept   = in_valid && in_ready;
  // flush kills, accept refills, EX fire empties, otherwise hold
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
    ctrl_d  = accept ? dec : ctrl_q;
    f3_d    = accept ? f3 : f3_q;
    rs1_d   = accept ? rs1 : rs1_q;
    rs2_d   = accept ? rs2 : rs2_q;
    rd_d    = accept ? rd : rd_q;
    imm_d   = accept ? imm : imm_q;
    pc_d    = accept ? in_pc : pc_q;
  end
  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      f3_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      f3_q    <= f3_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
    end
  end
  assign out_valid     = valid_q;
  assign out_alu_op    = ctrl_q.alu_op;
  assign out_a_sel     = ctrl_q.a_sel;
  assign out_alu_src   = ctrl_q.alu_src;
  assign out_wb_sel    = ctrl_q.wb_sel;
  assign out_reg_write = ctrl_q.reg_write;
  assign out_mem_read  = ctrl_q.mem_read;
  assign out_mem_write = ctrl_q.mem_write;
  assign out_branch    = ctrl_q.branch;
  assign out_jump      = ctrl_q.jump;
  assign out_jalr      = ctrl_q.jalr;
  assign out_illegal   = ctrl_q.illegal;
  assign out_funct3    = f3_q;
  assign out_imm       = imm_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_pc        = pc_q;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: directed self-checking bench for id_ctrl_stage
module tb_id_ctrl_stage;
  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [4:0]  out_alu_op, out_rs1, out_rs2, out_rd;
  logic [1:0]  out_a_sel, out_wb_sel;
  logic [2:0]  out_funct3;
  logic        out_alu_src, out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_jalr, out_illegal;
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00228333;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_LUI   = 32'h123453B7;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_XOR20 = 32'h4020C233;
  localparam logic [31:0] I_SUB   = 32'h40208233;
  localparam logic [31:0] I_SRAI  = 32'h4030D213;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_BEQ   = 32'hFE208EE3;
  localparam logic [31:0] I_NOP   = 32'h00000013;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_ADDX0 = 32'h00200333;

  id_ctrl_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_a_sel(out_a_sel), .out_alu_src(out_alu_src),
    .out_wb_sel(out_wb_sel), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_jalr(out_jalr), .out_funct3(out_funct3), .out_imm(out_imm), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = p;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    put(I_ADD, 32'h0);
    cyc; cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %0h want 0", in_ready); end
    n_cmp++; if (out_imm !== 32'h0) begin n_err++; $display("FAIL rst_imm got %h want 0", out_imm); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", out_pc); end
    n_cmp++; if (out_rd !== 5'h0) begin n_err++; $display("FAIL rst_rd got %0h want 0", out_rd); end
    n_cmp++; if (out_alu_op !== 5'h0) begin n_err++; $display("FAIL rst_alu_op got %0h want 0", out_alu_op); end
    n_cmp++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL rst_reg_write got %0h want 0", out_reg_write); end
    n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %0h want 0", out_illegal); end
    rst = 1'b0; in_valid = 1'b0;
    cyc;
  endtask

  task automatic test_add;
    put(I_ADD, 32'h40);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready got %0h want 1", in_ready); end
    cyc;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %0h want 1", out_valid); end
    n_cmp++; if (out_alu_op !== 5'h00) begin n_err++; $display("FAIL add_alu_op got %0h want 0", out_alu_op); end
    n_cmp++; if (out_reg_write !== 1'b1) begin n_err++; $display("FAIL add_reg_write got %0h want 1", out_reg_write); end
    n_cmp++; if (out_rd !== 5'd3) begin n_err++; $display("FAIL add_rd got %0d want 3", out_rd); end
    n_cmp++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin n_err++; $display("FAIL add_rs got %0d/%0d want 1/2", out_rs1, out_rs2); end
    n_cmp++; if (out_alu_src !== 1'b0 || out_a_sel !== 2'd0 || out_wb_sel !== 2'd0) begin n_err++; $display("FAIL add_muxes got %0h/%0h/%0h want 0/0/0", out_alu_src, out_a_sel, out_wb_sel); end
    n_cmp++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL add_pc got %h want 40", out_pc); end
    cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_load_use;
    put(I_LW, 32'h10);
    cyc;
    put(I_ADD6, 32'h14);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_stall got %0h want 0", in_ready); end
    n_cmp++; if (out_mem_read !== 1'b1 || out_rd !== 5'd5 || out_wb_sel !== 2'd1) begin n_err++; $display("FAIL lu_load got mr=%0h rd=%0d wb=%0h want 1/5/1", out_mem_read, out_rd, out_wb_sel); end
    n_cmp++; if (out_alu_src !== 1'b1 || out_imm !== 32'h0) begin n_err++; $display("FAIL lu_load_imm got src=%0h imm=%h want 1/0", out_alu_src, out_imm); end
    cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %0h want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_resume got %0h want 1", in_ready); end
    cyc;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_pc !== 32'h14) begin n_err++; $display("FAIL lu_dep got v=%0h rd=%0d pc=%h want 1/6/14", out_valid, out_rd, out_pc); end
    n_cmp++; if (out_mem_read !== 1'b0) begin n_err++; $display("FAIL lu_dep_mr got %0h want 0", out_mem_read); end
    cyc;
  endtask

  task automatic test_jal_lui;
    put(I_JAL, 32'h100);
    cyc;
    put(I_LUI, 32'h104);
    n_cmp++; if (out_valid !== 1'b1 || out_jump !== 1'b1 || out_jalr !== 1'b0) begin n_err++; $display("FAIL jal_jump got v=%0h j=%0h jr=%0h want 1/1/0", out_valid, out_jump, out_jalr); end
    n_cmp++; if (out_wb_sel !== 2'd2 || out_a_sel !== 2'd1 || out_alu_src !== 1'b1) begin n_err++; $display("FAIL jal_muxes got %0h/%0h/%0h want 2/1/1", out_wb_sel, out_a_sel, out_alu_src); end
    n_cmp++; if (out_imm !== 32'h8) begin n_err++; $display("FAIL jal_imm got %h want 8", out_imm); end
    n_cmp++; if (out_reg_write !== 1'b1 || out_rd !== 5'd1 || out_pc !== 32'h100) begin n_err++; $display("FAIL jal_wb got rw=%0h rd=%0d pc=%h want 1/1/100", out_reg_write, out_rd, out_pc); end
    cyc;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_imm !== 32'h12345000) begin n_err++; $display("FAIL lui_imm got v=%0h imm=%h want 1/12345000", out_valid, out_imm); end
    n_cmp++; if (out_a_sel !== 2'd2 || out_jump !== 1'b0 || out_rd !== 5'd7) begin n_err++; $display("FAIL lui_ctrl got a=%0h j=%0h rd=%0d want 2/0/7", out_a_sel, out_jump, out_rd); end
    cyc;
  endtask

  task automatic test_formats;
    put(I_SUB, 32'h180);
    cyc;
    put(I_SRAI, 32'h184);
    n_cmp++; if (out_alu_op !== 5'h08 || out_illegal !== 1'b0) begin n_err++; $display("FAIL sub_alu_op got %0h ill=%0h want 08/0", out_alu_op, out_illegal); end
    cyc;
    put(I_SW, 32'h188);
    n_cmp++; if (out_alu_op !== 5'h0D || out_imm !== 32'h403 || out_alu_src !== 1'b1) begin n_err++; $display("FAIL srai got op=%0h imm=%h src=%0h want 0d/403/1", out_alu_op, out_imm, out_alu_src); end
    cyc;
    put(I_BEQ, 32'h18C);
    n_cmp++; if (out_imm !== 32'h8 || out_mem_write !== 1'b1 || out_reg_write !== 1'b0 || out_funct3 !== 3'd2) begin n_err++; $display("FAIL sw got imm=%h mw=%0h rw=%0h f3=%0h want 8/1/0/2", out_imm, out_mem_write, out_reg_write, out_funct3); end
    cyc;
    in_valid = 1'b0;
    n_cmp++; if (out_imm !== 32'hFFFFFFFC || out_branch !== 1'b1 || out_alu_op !== 5'h08 || out_reg_write !== 1'b0 || out_alu_src !== 1'b0) begin n_err++; $display("FAIL beq got imm=%h br=%0h op=%0h rw=%0h src=%0h want fffffffc/1/08/0/0", out_imm, out_branch, out_alu_op, out_reg_write, out_alu_src); end
    cyc;
  endtask

  task automatic test_illegal;
    put(I_BAD, 32'h200);
    cyc;
    put(I_MUL, 32'h204);
    n_cmp++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_alu_src !== 1'b0) begin n_err++; $display("FAIL bad_op got v=%0h ill=%0h rw=%0h src=%0h want 1/1/0/0", out_valid, out_illegal, out_reg_write, out_alu_src); end
    cyc;
    put(I_XOR20, 32'h208);
`ifdef RV_MEXT_EN
    n_cmp++; if (out_alu_op !== 5'h10 || out_illegal !== 1'b0 || out_reg_write !== 1'b1) begin n_err++; $display("FAIL mul got op=%0h ill=%0h rw=%0h want 10/0/1", out_alu_op, out_illegal, out_reg_write); end
`else
    n_cmp++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_write !== 1'b0 || out_alu_op !== 5'h0) begin n_err++; $display("FAIL mul_illegal got v=%0h ill=%0h rw=%0h op=%0h want 1/1/0/0", out_valid, out_illegal, out_reg_write, out_alu_op); end
`endif
    cyc;
    in_valid = 1'b0;
    n_cmp++; if (out_illegal !== 1'b1 || out_reg_write !== 1'b0) begin n_err++; $display("FAIL xor20 got ill=%0h rw=%0h want 1/0", out_illegal, out_reg_write); end
    cyc;
  endtask

  task automatic test_stall_flush;
    out_ready = 1'b0;
    put(I_ADD, 32'h300);
    cyc;
    put(I_LUI, 32'h304);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d] got %0h want 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_rd !== 5'd3 || out_reg_write !== 1'b1) begin n_err++; $display("FAIL hold_out[%0d] got v=%0h pc=%h rd=%0d rw=%0h want 1/300/3/1", k, out_valid, out_pc, out_rd, out_reg_write); end
      cyc;
    end
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %0h want 0", in_ready); end
    cyc;
    flush = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0h want 0", out_valid); end
    cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_nocap got %0h want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_x0;
    put(I_NOP, 32'h400);
    cyc;
    put(I_LW0, 32'h404);
    n_cmp++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || out_alu_src !== 1'b1 || out_illegal !== 1'b0) begin n_err++; $display("FAIL nop got v=%0h rw=%0h src=%0h ill=%0h want 1/0/1/0", out_valid, out_reg_write, out_alu_src, out_illegal); end
    cyc;
    put(I_ADDX0, 32'h408);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL x0_nostall got %0h want 1", in_ready); end
    n_cmp++; if (out_mem_read !== 1'b1 || out_rd !== 5'd0 || out_reg_write !== 1'b0) begin n_err++; $display("FAIL lw_x0 got mr=%0h rd=%0d rw=%0h want 1/0/0", out_mem_read, out_rd, out_reg_write); end
    cyc;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h408 || out_rd !== 5'd6) begin n_err++; $display("FAIL x0_reader got v=%0h pc=%h rd=%0d want 1/408/6", out_valid, out_pc, out_rd); end
    cyc;
  endtask

  task automatic test_rst_mid;
    out_ready = 1'b0;
    put(I_ADD, 32'h500);
    cyc;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_load got %0h want 1", out_valid); end
    out_ready = 1'b1;
    put(I_LUI, 32'h504);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready got %0h want 0", in_ready); end
    cyc;
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_imm !== 32'h0) begin n_err++; $display("FAIL mid_rst got v=%0h pc=%h imm=%h want 0/0/0", out_valid, out_pc, out_imm); end
    rst = 1'b0;
    in_valid = 1'b0;
    cyc;
  endtask

  initial begin
    in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1; rst = 1'b1;
    test_reset;
    test_add;
    test_load_use;
    test_jal_lui;
    test_formats;
    test_illegal;
    test_stall_flush;
    test_x0;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
